// File: rtl/mm_to_emib_write_pkg.sv
// Shared constants and FSM encoding for the MM-to-EMIB write path.
package mm_to_emib_write_pkg;

  localparam int unsigned RAM_WIDTH = 16;
  localparam int unsigned ADDR_SIZE = 11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_DONE = 3'd2,
    JUDGE_ERR  = 3'd3,
    WRITE_ERR  = 3'd4
  } emib_wr_state_e;

endpackage

// File: rtl/mm_to_emib_write_if.sv
// MM write-data stream: valid/data from the MM module, ready back from the writer.
interface mm_to_emib_write_if #(
  parameter int unsigned DATA_W = mm_to_emib_write_pkg::RAM_WIDTH
) ();

  logic              mm_data_vld;
  logic [DATA_W-1:0] mm_data;
  logic              mm_data_rdy;

  modport master (output mm_data_vld, output mm_data, input mm_data_rdy);
  modport slave  (input mm_data_vld, input mm_data, output mm_data_rdy);

endinterface

// File: rtl/mm_emib_sync_fifo.sv
// Single-clock FIFO with show-ahead read data, flush and occupancy count.
module mm_emib_sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_count = wr_ptr - rd_ptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mm_to_emib_write.sv
// Buffers an MM write burst and writes it to EMIB RAM at start_addr + n.
// Optional stall timeout enabled by defining MM_TO_EMIB_TIMEOUT_EN.
module mm_to_emib_write
  import mm_to_emib_write_pkg::*;
#(
  parameter int unsigned DATA_W      = RAM_WIDTH,
  parameter int unsigned ADDR_W      = ADDR_SIZE,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic              i_error,
  input  logic [ADDR_W-1:0] i_mm_data_len,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_offset_addr,
  mm_to_emib_write_if.slave mm,
  output logic              o_emib_wr_en,
  output logic [ADDR_W-1:0] o_emib_addr,
  output logic [DATA_W-1:0] o_emib_data,
  output logic              o_write_done,
  output logic              o_write_error,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_wr_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  emib_wr_state_e    state_q, state_n;
  logic [ADDR_W-1:0] len_q, len_n;
  logic [ADDR_W-1:0] start_q, start_n;
  logic [ADDR_W-1:0] acc_q, acc_n;
  logic [ADDR_W-1:0] wr_cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic              wr_en_n;
  logic              rdy_q, rdy_n;
  logic              timeout_hit;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_cnt, fifo_cnt_n;

`ifdef MM_TO_EMIB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall_q, stall_n;
`endif

  assign mm.mm_data_rdy = rdy_q;

  mm_emib_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .i_wdata (mm.mm_data),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_cnt)
  );

  always_comb begin
    state_n     = state_q;
    len_n       = len_q;
    start_n     = start_q;
    acc_n       = acc_q;
    wr_cnt_n    = o_wr_count;
    wr_en_n     = 1'b0;
    addr_n      = o_emib_addr;
    data_n      = o_emib_data;
    timeout_hit = 1'b0;
`ifdef MM_TO_EMIB_TIMEOUT_EN
    stall_n     = stall_q;
`endif
    fifo_push   = mm.mm_data_vld && rdy_q && !fifo_full;

    unique case (state_q)
      IDLE: begin
        if (i_wr_req) begin
          len_n    = i_mm_data_len;
          start_n  = i_base_addr + i_offset_addr;
          acc_n    = '0;
          wr_cnt_n = '0;
          state_n  = JUDGE_ERR;
        end
      end
      JUDGE_ERR: begin
        if (i_error)            state_n = WRITE_ERR;
        else if (len_q == '0)   state_n = WRITE_DONE;
        else                    state_n = WRITE;
`ifdef MM_TO_EMIB_TIMEOUT_EN
        stall_n = '0;
`endif
      end
      WRITE: begin
        if (o_wr_count == len_q && fifo_empty) state_n = WRITE_DONE;
`ifdef MM_TO_EMIB_TIMEOUT_EN
        if (fifo_push) begin
          stall_n = '0;
        end else if (acc_q < len_q) begin
          if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
            state_n     = WRITE_ERR;
          end else begin
            stall_n = stall_q + 1'b1;
          end
        end
`endif
      end
      WRITE_DONE: state_n = IDLE;
      WRITE_ERR:  state_n = IDLE;
      default:    state_n = IDLE;
    endcase

    // A timeout suppresses the pop so buffered words are discarded, not written.
    fifo_pop   = (state_q == WRITE) && !fifo_empty && !timeout_hit;
    fifo_flush = (state_q == WRITE_ERR);

    if (fifo_push) acc_n = acc_q + 1'b1;
    if (fifo_pop) begin
      wr_en_n  = 1'b1;
      addr_n   = start_q + o_wr_count;
      data_n   = fifo_rdata;
      wr_cnt_n = o_wr_count + 1'b1;
    end

    // Ready is registered from next-cycle occupancy, equivalent to !full in that cycle.
    fifo_cnt_n = fifo_flush ? '0 : fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    rdy_n      = (state_n == WRITE) && (fifo_cnt_n != CW'(FIFO_DEPTH)) && (acc_n < len_n);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      start_q       <= '0;
      acc_q         <= '0;
      rdy_q         <= 1'b0;
      o_emib_wr_en  <= 1'b0;
      o_emib_addr   <= '0;
      o_emib_data   <= '0;
      o_write_done  <= 1'b0;
      o_write_error <= 1'b0;
      o_busy        <= 1'b0;
      o_wr_count    <= '0;
`ifdef MM_TO_EMIB_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_n;
      len_q         <= len_n;
      start_q       <= start_n;
      acc_q         <= acc_n;
      rdy_q         <= rdy_n;
      o_emib_wr_en  <= wr_en_n;
      o_emib_addr   <= addr_n;
      o_emib_data   <= data_n;
      o_write_done  <= (state_n == WRITE_DONE);
      o_write_error <= (state_n == WRITE_ERR);
      o_busy        <= (state_n != IDLE);
      o_wr_count    <= wr_cnt_n;
`ifdef MM_TO_EMIB_TIMEOUT_EN
      stall_q       <= stall_n;
`endif
    end
  end

endmodule
